// File: rtl/audio_sample_packetizer.sv
// audio_sample_packetizer: FIFO-buffered L-PCM frames packed into HDMI Audio Sample packets (type 0x02)
// with generated IEC 60958 C/P bits; layout 0 (2 ch, 4 frames/packet) or layout 1 (8 ch, 1 frame/packet).
module audio_sample_packetizer #(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int CHANNELS = 2,
    parameter int FIFO_DEPTH = 8,
    parameter logic [3:0] SAMPLING_FREQUENCY = 4'b0010
) (
    input  logic                                clk_pixel,
    input  logic                                reset,
    input  logic                                sample_valid,
    output logic                                sample_ready,
    input  logic [CHANNELS*AUDIO_BIT_WIDTH-1:0] sample_word,
    output logic                                packet_valid,
    input  logic                                packet_ready,
    output logic [23:0]                         header,
    output logic [223:0]                        sub,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_level
);
    localparam int W = AUDIO_BIT_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int K = (CHANNELS == 8) ? 1 : 4;
    localparam logic LAYOUT = (CHANNELS == 8);
    localparam logic [3:0] WORD_LEN = (W == 16) ? 4'b0010 : (W == 20) ? 4'b1010 : 4'b1011;

    if (!(W == 16 || W == 20 || W == 24)) begin : g_bad_width
        $error("AUDIO_BIT_WIDTH must be 16, 20 or 24");
    end
    if (!(CHANNELS == 2 || CHANNELS == 8)) begin : g_bad_channels
        $error("CHANNELS must be 2 or 8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    // Channel-status bit idx for channel n; fields sit on 4-bit boundaries (20, 24, 32).
    function automatic logic cs_bit(input logic [3:0] n, input logic [7:0] idx);
        return (idx == 8'd2) || (idx[7:2] == 6'd5 && n[idx[1:0]]) ||
               (idx[7:2] == 6'd6 && SAMPLING_FREQUENCY[idx[1:0]]) ||
               (idx[7:2] == 6'd8 && WORD_LEN[idx[1:0]]);
    endfunction

    function automatic logic [55:0] subpkt(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] na, input logic [3:0] nb,
                                           input logic [7:0] idx);
        logic [23:0] a24, b24;
        logic ca, cb;
        a24 = 24'(a) << (24 - W);
        b24 = 24'(b) << (24 - W);
        ca = cs_bit(na, idx);
        cb = cs_bit(nb, idx);
        return {^{b24, cb}, cb, 2'b00, ^{a24, ca}, ca, 2'b00, b24, a24};
    endfunction

    logic [CHANNELS*W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]  wr_q, rd_q;
    logic [2:0]   count_q;
    logic [7:0]   fc_q;
    logic [3:0]   b_q;
    logic [55:0]  sub_q [4];
    logic [55:0]  pk [4];
    logic [3:0]   present;
    logic [CHANNELS*W-1:0] head;
    logic full, empty, push, pop, handshake;

    assign fifo_level   = wr_q - rd_q;
    assign full         = fifo_level == (AW + 1)'(FIFO_DEPTH);
    assign empty        = wr_q == rd_q;
    assign sample_ready = !full && !reset;
    assign push         = sample_valid && sample_ready;
    assign packet_valid = count_q != 3'd0;
    assign handshake    = packet_valid && packet_ready;
    assign pop          = !empty && !handshake && count_q < 3'(K);
    assign head         = mem[rd_q[AW-1:0]];
    assign sub          = {sub_q[3], sub_q[2], sub_q[1], sub_q[0]};

    for (genvar i = 0; i < 4; i++) begin : g_pk
        if (CHANNELS == 8) begin : g_l1
            assign pk[i] = subpkt(head[2*i*W +: W], head[(2*i+1)*W +: W], 4'(2*i+1), 4'(2*i+2), fc_q);
        end else begin : g_l0
            assign pk[i] = subpkt(head[W-1:0], head[2*W-1:W], 4'd1, 4'd2, fc_q);
        end
    end

    always_comb begin
        present = '0;
        for (int i = 0; i < 4; i++) present[i] = LAYOUT || (3'(i) < count_q);
        header = packet_valid ? {b_q, 4'b0000, 3'b000, LAYOUT, present, 8'h02} : 24'h0;
    end

    always_ff @(posedge clk_pixel) begin
        if (push) mem[wr_q[AW-1:0]] <= sample_word;
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            fc_q    <= '0;
            b_q     <= '0;
            for (int i = 0; i < 4; i++) sub_q[i] <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) begin
                rd_q <= rd_q + 1'b1;
                fc_q <= (fc_q == 8'd191) ? 8'd0 : fc_q + 8'd1;
            end
            if (handshake) begin
                count_q <= '0;
                b_q     <= '0;
                for (int i = 0; i < 4; i++) sub_q[i] <= '0;
            end else if (pop) begin
                count_q <= count_q + 3'd1;
                // layout 1 fills all four subpackets from one frame; layout 0 fills slot count_q
                for (int i = 0; i < 4; i++) begin
                    if (LAYOUT || count_q[1:0] == 2'(i)) begin
                        sub_q[i] <= pk[i];
                        b_q[i]   <= (!LAYOUT || i == 0) && fc_q == 8'd0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_audio_sample_packetizer.sv
// tb_audio_sample_packetizer: 2ch/16b and 8ch/24b instances checked against a frame-queue model
// that derives each packet from the IEC 60958 channel-status block and frame order.
module tb_audio_sample_packetizer;
    logic clk = 1'b0, rst = 1'b0;
    logic a_valid = 1'b0, a_ready, a_pv, a_pr = 1'b0;
    logic [31:0] a_word = '0;
    logic [23:0] a_hdr;
    logic [223:0] a_sub;
    logic [3:0] a_lvl;
    logic b_valid = 1'b0, b_ready, b_pv, b_pr = 1'b0;
    logic [191:0] b_word = '0;
    logic [23:0] b_hdr;
    logic [223:0] b_sub;
    logic [2:0] b_lvl;

    int n_cmp = 0, n_bad = 0;
    logic [31:0] aq[$];
    logic [191:0] bq[$];
    int a_seq = 0, b_seq = 0;

    always #5 clk = ~clk;

    audio_sample_packetizer #(.AUDIO_BIT_WIDTH(16), .CHANNELS(2), .FIFO_DEPTH(8)) dut_a (
        .clk_pixel(clk), .reset(rst), .sample_valid(a_valid), .sample_ready(a_ready),
        .sample_word(a_word), .packet_valid(a_pv), .packet_ready(a_pr), .header(a_hdr),
        .sub(a_sub), .fifo_level(a_lvl));

    audio_sample_packetizer #(.AUDIO_BIT_WIDTH(24), .CHANNELS(8), .FIFO_DEPTH(4)) dut_b (
        .clk_pixel(clk), .reset(rst), .sample_valid(b_valid), .sample_ready(b_ready),
        .sample_word(b_word), .packet_valid(b_pv), .packet_ready(b_pr), .header(b_hdr),
        .sub(b_sub), .fifo_level(b_lvl));

    function automatic logic [191:0] cstat(input int n, input int wb);
        logic [191:0] s;
        s = '0;
        s[2] = 1'b1;
        s[23:20] = 4'(n);
        s[27:24] = 4'b0010;
        s[35:32] = (wb == 16) ? 4'b0010 : (wb == 20) ? 4'b1010 : 4'b1011;
        return s;
    endfunction

    function automatic logic [55:0] exp_sp(input logic [23:0] a, input logic [23:0] b,
                                           input int na, input int nb, input int wb, input int fi);
        logic [191:0] sa, sb;
        logic ca, cb, pa, pb;
        sa = cstat(na, wb);
        sb = cstat(nb, wb);
        ca = sa[fi];
        cb = sb[fi];
        pa = (($countones(a) + int'(ca)) % 2) == 1;
        pb = (($countones(b) + int'(cb)) % 2) == 1;
        return {pb, cb, 2'b00, pa, ca, 2'b00, b, a};
    endfunction

    function automatic void exp_a(input int n, output logic [23:0] h, output logic [223:0] s);
        logic [3:0] bf;
        int fi;
        bf = '0;
        s = '0;
        for (int i = 0; i < n; i++) begin
            fi = (a_seq + i) % 192;
            bf[i] = (fi == 0);
            s[i*56 +: 56] = exp_sp({aq[i][15:0], 8'h00}, {aq[i][31:16], 8'h00}, 1, 2, 16, fi);
        end
        h = {bf, 4'h0, 4'h0, 4'((1 << n) - 1), 8'h02};
    endfunction

    function automatic void exp_b(output logic [23:0] h, output logic [223:0] s);
        logic [191:0] f;
        int fi;
        f = bq[0];
        fi = b_seq % 192;
        for (int i = 0; i < 4; i++)
            s[i*56 +: 56] = exp_sp(f[2*i*24 +: 24], f[(2*i+1)*24 +: 24], 2*i+1, 2*i+2, 24, fi);
        h = {3'b000, fi == 0, 4'h0, 8'h1F, 8'h02};
    endfunction

    function automatic void take_a(input int n);
        repeat (n) void'(aq.pop_front());
        a_seq += n;
    endfunction

    function automatic void take_b();
        void'(bq.pop_front());
        b_seq += 1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        a_valid = 1'b0; a_pr = 1'b0; b_valid = 1'b0; b_pr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        aq.delete(); bq.delete();
        a_seq = 0; b_seq = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_pv, a_ready, a_lvl, a_hdr, b_pv, b_ready, b_lvl, b_hdr} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: a pv=%b rdy=%b lvl=%0d hdr=%h b pv=%b rdy=%b lvl=%0d hdr=%h, want all 0",
                     a_pv, a_ready, a_lvl, a_hdr, b_pv, b_ready, b_lvl, b_hdr);
        end
        n_cmp++;
        if (a_sub !== '0 || b_sub !== '0) begin
            n_bad++;
            $display("FAIL reset_sub: a=%h b=%h want 0", a_sub, b_sub);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: a=%b b=%b want 1", a_ready, b_ready);
        end
    endtask

    task automatic test_four_frames();
        logic [23:0] eh;
        logic [223:0] es;
        do_reset();
        repeat (4) begin
            @(negedge clk);
            a_valid = 1'b1;
            a_word = {16'hABCD, 16'h1234};
            if (a_ready) aq.push_back(a_word);
        end
        @(negedge clk);
        a_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (a_hdr !== 24'h100F02) begin
            n_bad++;
            $display("FAIL four_header: got %h want 100f02", a_hdr);
        end
        n_cmp++;
        if (a_sub[55:0] !== 56'h08_AB_CD_00_12_34_00) begin
            n_bad++;
            $display("FAIL four_sub0: got %h want 08abcd00123400", a_sub[55:0]);
        end
        exp_a(4, eh, es);
        n_cmp++;
        if (a_sub !== es) begin
            n_bad++;
            $display("FAIL four_sub_all: got %h want %h", a_sub, es);
        end
        a_pr = 1'b1;
        take_a(4);
        @(negedge clk);
        a_pr = 1'b0;
        n_cmp++;
        if (a_pv !== 1'b0 || a_hdr !== 24'h0) begin
            n_bad++;
            $display("FAIL four_after_take: pv=%b hdr=%h want 0/0", a_pv, a_hdr);
        end
    endtask

    task automatic test_single_frame();
        logic [23:0] eh;
        logic [223:0] es;
        do_reset();
        @(negedge clk);
        a_valid = 1'b1;
        a_word = $urandom;
        if (a_ready) aq.push_back(a_word);
        @(negedge clk);
        a_valid = 1'b0;
        a_pr = 1'b1;
        for (int k = 0; k < 10 && !a_pv; k++) @(negedge clk);
        n_cmp++;
        if (!a_pv) begin
            n_bad++;
            $display("FAIL single_timeout: packet_valid=%b want 1", a_pv);
        end else begin
            exp_a(1, eh, es);
            n_cmp++;
            if (a_hdr[23:8] !== 16'h1001 || a_sub[223:56] !== '0) begin
                n_bad++;
                $display("FAIL single_hdr: hb2hb1=%h upper_sub=%h want 1001/0", a_hdr[23:8], a_sub[223:56]);
            end
            n_cmp++;
            if ({a_hdr, a_sub} !== {eh, es}) begin
                n_bad++;
                $display("FAIL single_pkt: got %h %h want %h %h", a_hdr, a_sub, eh, es);
            end
            take_a(1);
        end
        @(negedge clk);
        a_pr = 1'b0;
        n_cmp++;
        if (a_pv !== 1'b0) begin
            n_bad++;
            $display("FAIL single_cleared: pv=%b want 0", a_pv);
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] eh;
        logic [223:0] es;
        int acc;
        do_reset();
        acc = 0;
        repeat (20) begin
            @(negedge clk);
            a_valid = 1'b1;
            a_word = $urandom;
            if (a_ready) begin
                aq.push_back(a_word);
                acc++;
            end
        end
        @(negedge clk);
        a_valid = 1'b0;
        n_cmp++;
        if (acc != 12 || a_ready !== 1'b0 || a_lvl !== 4'd8) begin
            n_bad++;
            $display("FAIL bp_fill: accepted=%0d ready=%b level=%0d want 12/0/8", acc, a_ready, a_lvl);
        end
        exp_a(4, eh, es);
        n_cmp++;
        if ({a_hdr, a_sub} !== {eh, es}) begin
            n_bad++;
            $display("FAIL bp_pkt1: got %h %h want %h %h", a_hdr, a_sub, eh, es);
        end
        a_pr = 1'b1;
        take_a(4);
        @(negedge clk);
        a_pr = 1'b0;
        repeat (4) @(negedge clk);
        exp_a(4, eh, es);
        n_cmp++;
        if (a_lvl !== 4'd4 || a_ready !== 1'b1 || {a_hdr, a_sub} !== {eh, es}) begin
            n_bad++;
            $display("FAIL bp_refill: level=%0d ready=%b hdr=%h want 4/1/%h", a_lvl, a_ready, a_hdr, eh);
        end
    endtask

    task automatic test_stream_a(input int total);
        logic [23:0] eh;
        logic [223:0] es;
        int pushed, cyc, n;
        do_reset();
        pushed = 0;
        cyc = 0;
        while ((pushed < total || aq.size() > 0) && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            a_pr = ($urandom_range(0, 3) != 0);
            if (a_pv && a_pr) begin
                n = $countones(a_hdr[11:8]);
                n_cmp++;
                if (n < 1 || n > aq.size() || a_hdr[11:8] !== 4'((1 << n) - 1)) begin
                    n_bad++;
                    $display("FAIL stream_a_present: present=%b queued=%0d", a_hdr[11:8], aq.size());
                end else begin
                    exp_a(n, eh, es);
                    n_cmp++;
                    if ({a_hdr, a_sub} !== {eh, es}) begin
                        n_bad++;
                        $display("FAIL stream_a_pkt seq=%0d: got %h %h want %h %h", a_seq, a_hdr, a_sub, eh, es);
                    end
                    take_a(n);
                end
            end
            a_valid = (pushed < total) && ($urandom_range(0, 9) < 7);
            a_word = $urandom;
            if (a_valid && a_ready) begin
                aq.push_back(a_word);
                pushed++;
            end
        end
        @(negedge clk);
        a_valid = 1'b0;
        a_pr = 1'b0;
        n_cmp++;
        if (a_seq != total) begin
            n_bad++;
            $display("FAIL stream_a_count: delivered=%0d want %0d", a_seq, total);
        end
    endtask

    task automatic test_layout1();
        logic [23:0] eh;
        logic [223:0] es;
        do_reset();
        @(negedge clk);
        for (int n = 1; n <= 8; n++) b_word[(n-1)*24 +: 24] = {3{8'(n)}};
        b_valid = 1'b1;
        if (b_ready) bq.push_back(b_word);
        @(negedge clk);
        b_valid = 1'b0;
        for (int k = 0; k < 10 && !b_pv; k++) @(negedge clk);
        n_cmp++;
        if (!b_pv || b_hdr !== 24'h101F02) begin
            n_bad++;
            $display("FAIL l1_header: pv=%b hdr=%h want 1/101f02", b_pv, b_hdr);
        end
        n_cmp++;
        if (b_sub[23:0] !== 24'h010101 || b_sub[47:24] !== 24'h020202 ||
            b_sub[191:168] !== 24'h070707 || b_sub[215:192] !== 24'h080808) begin
            n_bad++;
            $display("FAIL l1_samples: got %h want ch1/2/7/8 in place", b_sub);
        end
        exp_b(eh, es);
        n_cmp++;
        if (b_sub !== es) begin
            n_bad++;
            $display("FAIL l1_sub: got %h want %h", b_sub, es);
        end
        b_pr = 1'b1;
        take_b();
        @(negedge clk);
        b_pr = 1'b0;
        n_cmp++;
        if (b_pv !== 1'b0) begin
            n_bad++;
            $display("FAIL l1_cleared: pv=%b want 0", b_pv);
        end
    endtask

    task automatic test_stream_b(input int total);
        logic [23:0] eh;
        logic [223:0] es;
        int pushed, cyc;
        do_reset();
        pushed = 0;
        cyc = 0;
        while ((pushed < total || bq.size() > 0) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            b_pr = ($urandom_range(0, 2) != 0);
            if (b_pv && b_pr) begin
                n_cmp++;
                if (bq.size() == 0) begin
                    n_bad++;
                    $display("FAIL stream_b_extra: packet with empty model queue hdr=%h", b_hdr);
                end else begin
                    exp_b(eh, es);
                    n_cmp++;
                    if ({b_hdr, b_sub} !== {eh, es}) begin
                        n_bad++;
                        $display("FAIL stream_b_pkt seq=%0d: got %h %h want %h %h", b_seq, b_hdr, b_sub, eh, es);
                    end
                    take_b();
                end
            end
            b_valid = (pushed < total) && ($urandom_range(0, 1) == 1);
            for (int c = 0; c < 6; c++) b_word[c*32 +: 32] = $urandom;
            if (b_valid && b_ready) begin
                bq.push_back(b_word);
                pushed++;
            end
        end
        @(negedge clk);
        b_valid = 1'b0;
        b_pr = 1'b0;
        n_cmp++;
        if (b_seq != total) begin
            n_bad++;
            $display("FAIL stream_b_count: delivered=%0d want %0d", b_seq, total);
        end
    endtask

    task automatic test_reset_midop();
        logic [23:0] eh;
        logic [223:0] es;
        do_reset();
        repeat (11) begin
            @(negedge clk);
            a_valid = 1'b1;
            a_word = $urandom;
            if (a_ready) aq.push_back(a_word);
        end
        @(negedge clk);
        a_valid = 1'b0;
        repeat (3) @(negedge clk);
        a_pr = 1'b1;
        take_a(4);
        @(negedge clk);
        a_pr = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (a_hdr[11:8] !== 4'h3 || a_lvl !== 4'd5) begin
            n_bad++;
            $display("FAIL midop_setup: present=%b level=%0d want 0011/5", a_hdr[11:8], a_lvl);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (a_pv !== 1'b0 || a_lvl !== 4'd0 || a_hdr !== 24'h0) begin
            n_bad++;
            $display("FAIL midop_reset: pv=%b level=%0d hdr=%h want 0/0/0", a_pv, a_lvl, a_hdr);
        end
        @(negedge clk);
        rst = 1'b0;
        aq.delete();
        a_seq = 0;
        @(negedge clk);
        a_valid = 1'b1;
        a_word = $urandom;
        if (a_ready) aq.push_back(a_word);
        @(negedge clk);
        a_valid = 1'b0;
        a_pr = 1'b1;
        for (int k = 0; k < 10 && !a_pv; k++) @(negedge clk);
        exp_a(1, eh, es);
        n_cmp++;
        if (!a_pv || a_hdr[20] !== 1'b1 || {a_hdr, a_sub} !== {eh, es}) begin
            n_bad++;
            $display("FAIL midop_first_b: pv=%b hdr=%h want 1/%h", a_pv, a_hdr, eh);
        end
        take_a(1);
        @(negedge clk);
        a_pr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_four_frames();
        test_single_frame();
        test_backpressure();
        test_stream_a(400);
        test_layout1();
        test_stream_b(60);
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
